// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue scoreboard: OP_type encodings,
// the default in-flight depth and the per-op register-usage record.
package issue_scoreboard_pkg;

    // Default maximum outstanding writes tracked per architectural register.
    localparam int SB_MAX_INFLIGHT = 3;

    // Decoder OP_type encodings (one-hot, 7 bits).
    localparam logic [6:0] R_TYPE = 7'b000_0001;
    localparam logic [6:0] I_TYPE = 7'b000_0010;
    localparam logic [6:0] S_TYPE = 7'b000_0100;
    localparam logic [6:0] B_TYPE = 7'b000_1000;
    localparam logic [6:0] U_TYPE = 7'b001_0000;
    localparam logic [6:0] J_TYPE = 7'b010_0000;
    localparam logic [6:0] X_TYPE = 7'b100_0000;

    // Which register fields an instruction actually reads or writes.
    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
    } reg_use_t;

endpackage

// File: rtl/issue_scoreboard_counter.sv
// Per-register in-flight write counter. Counts up on issue, down on
// retire; a simultaneous inc and dec leaves the count unchanged.
module sb_reg_counter
    import issue_scoreboard_pkg::*;
#(
    parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic full
);

    logic [CNT_W-1:0] cnt;

    // Up/down count; the caller guarantees inc only when not full and dec only when not zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);
    assign full = (cnt == CNT_W'(MAX_INFLIGHT));

endmodule

// File: rtl/issue_scoreboard.sv
// Register scoreboard between decode and execute. Holds the ID-stage
// instruction while a source has an outstanding write or its destination
// already has MAX_INFLIGHT writes pending, and counts hazard stalls.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int REG_NUM      = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
    parameter int PERF_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [6:0]            id_op_type,
    input  logic                  ex_ready,
    input  logic                  flush,
    output logic                  id_ready,
    output logic                  issue_fire,
    output logic                  illegal,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic [REG_NUM-1:0]    busy_mask,
    output logic [PERF_W-1:0]     stall_cnt,
    output logic                  wb_underflow
);

    reg_use_t           use_q;
    logic [REG_NUM-1:0] zero;
    logic [REG_NUM-1:0] full;
    logic               hazard;
    logic               stall_evt;
    logic               wb_err;

    // Decode which register fields the current op type touches.
    always_comb begin
        use_q = '0;
        case (id_op_type)
            R_TYPE:         use_q = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b1};
            I_TYPE:         use_q = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1};
            S_TYPE, B_TYPE: use_q = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0};
            U_TYPE, J_TYPE: use_q = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1};
            default:        use_q = '0;
        endcase
    end

    // x0 is hardwired: never busy, never full.
    assign zero[0] = 1'b1;
    assign full[0] = 1'b0;

    for (genvar i = 1; i < REG_NUM; i++) begin : g_cnt
        logic inc;
        logic dec;
        assign inc = issue_fire && use_q.writes_rd && (id_rd == REG_ADDR_W'(i));
        assign dec = wb_valid && (wb_rd == REG_ADDR_W'(i)) && !zero[i];
        sb_reg_counter #(
            .MAX_INFLIGHT (MAX_INFLIGHT)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (inc),
            .dec  (dec),
            .zero (zero[i]),
            .full (full[i])
        );
    end

    // Sources are blocked by any pending write; destination only when its counter is full.
    assign hazard = (use_q.uses_rs1 && !zero[id_rs1])
                  | (use_q.uses_rs2 && !zero[id_rs2])
                  | (use_q.writes_rd && full[id_rd]);

    assign id_ready   = ex_ready && !flush && !hazard;
    assign issue_fire = id_valid && id_ready;
    assign illegal    = id_valid && (id_op_type == X_TYPE);
    assign busy_mask  = ~zero;

    assign stall_evt = id_valid && ex_ready && !flush && hazard;
    assign wb_err    = wb_valid && (wb_rd != '0) && zero[wb_rd];

    // Saturating count of cycles lost to register hazards.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_evt && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

    // Sticky flag for a writeback to a register with nothing in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_underflow <= 1'b0;
        end else if (wb_err) begin
            wb_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard with hand-computed expectations.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [6:0]  id_op_type;
    logic        ex_ready;
    logic        flush;
    logic        id_ready;
    logic        issue_fire;
    logic        illegal;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] busy_mask;
    logic [15:0] stall_cnt;
    logic        wb_underflow;

    int n_cmp = 0;
    int n_bad = 0;

    issue_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_op_type   (id_op_type),
        .ex_ready     (ex_ready),
        .flush        (flush),
        .id_ready     (id_ready),
        .issue_fire   (issue_fire),
        .illegal      (illegal),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .busy_mask    (busy_mask),
        .stall_cnt    (stall_cnt),
        .wb_underflow (wb_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [6:0] op,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        id_valid   = v;
        id_op_type = op;
        id_rs1     = rs1;
        id_rs2     = rs2;
        id_rd      = rd;
        #1;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd);
        wb_valid = v;
        wb_rd    = rd;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = '0;
        set_id(1'b0, X_TYPE, 5'd0, 5'd0, 5'd0);
        step(); step();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_busy", busy_mask, 32'h0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_uflow", 32'(wb_underflow), 32'd0);

        // R-type rd=5 issues, busy next cycle
        set_id(1'b1, R_TYPE, 5'd1, 5'd2, 5'd5);
        check("r_ready", 32'(id_ready), 32'd1);
        check("r_fire", 32'(issue_fire), 32'd1);
        check("r_legal", 32'(illegal), 32'd0);
        step();
        set_id(1'b0, R_TYPE, 5'd0, 5'd0, 5'd0);
        check("r_busy5", busy_mask, 32'h0000_0020);

        // RAW: I-type rd=3 then B-type rs1=3
        set_id(1'b1, I_TYPE, 5'd0, 5'd0, 5'd3);
        check("raw_i_ready", 32'(id_ready), 32'd1);
        step();
        set_id(1'b1, B_TYPE, 5'd3, 5'd0, 5'd0);
        check("raw_b_stall", 32'(id_ready), 32'd0);
        check("raw_b_nofire", 32'(issue_fire), 32'd0);
        step();
        check("raw_stall1", 32'(stall_cnt), 32'd1);
        step();
        check("raw_stall2", 32'(stall_cnt), 32'd2);
        set_wb(1'b1, 5'd3);
        check("raw_no_bypass", 32'(id_ready), 32'd0);
        step();
        set_wb(1'b0, 5'd0);
        check("raw_ready_n1", 32'(id_ready), 32'd1);
        check("raw_stall3", 32'(stall_cnt), 32'd3);
        step();
        set_id(1'b0, B_TYPE, 5'd0, 5'd0, 5'd0);
        check("raw_busy", busy_mask, 32'h0000_0020);

        // Saturation on rd=7
        set_id(1'b1, I_TYPE, 5'd0, 5'd0, 5'd7);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("sat_issue%0d", k), 32'(id_ready), 32'd1);
            step();
        end
        check("sat_full_hold", 32'(id_ready), 32'd0);
        set_id(1'b1, S_TYPE, 5'd7, 5'd0, 5'd0);
        check("sat_s_stall", 32'(id_ready), 32'd0);
        set_id(1'b1, I_TYPE, 5'd0, 5'd0, 5'd7);
        set_wb(1'b1, 5'd7);
        check("sat_wb_same", 32'(id_ready), 32'd0);
        step();
        set_wb(1'b0, 5'd0);
        check("sat_4th_ready", 32'(id_ready), 32'd1);
        check("sat_stall4", 32'(stall_cnt), 32'd4);
        step();
        set_id(1'b0, I_TYPE, 5'd0, 5'd0, 5'd0);
        // Drain: count must be back at 3
        set_wb(1'b1, 5'd7);
        step(); step();
        check("sat_drain2", 32'(busy_mask[7]), 32'd1);
        step();
        set_wb(1'b0, 5'd0);
        check("sat_drain3", 32'(busy_mask[7]), 32'd0);
        check("sat_stall_hold", 32'(stall_cnt), 32'd4);

        // Simultaneous inc/dec on rd=9
        set_id(1'b1, I_TYPE, 5'd0, 5'd0, 5'd9);
        step();
        set_wb(1'b1, 5'd9);
        check("sim_ready", 32'(id_ready), 32'd1);
        step();
        set_id(1'b0, I_TYPE, 5'd0, 5'd0, 5'd0);
        check("sim_busy9", 32'(busy_mask[9]), 32'd1);
        step();
        set_wb(1'b0, 5'd0);
        check("sim_cnt_was1", 32'(busy_mask[9]), 32'd0);
        check("sim_uflow", 32'(wb_underflow), 32'd0);

        // x0 destination and X-type
        set_id(1'b1, U_TYPE, 5'd0, 5'd0, 5'd0);
        check("u_x0_ready", 32'(id_ready), 32'd1);
        step();
        check("u_x0_busy", busy_mask, 32'h0000_0020);
        set_id(1'b1, X_TYPE, 5'd5, 5'd5, 5'd5);
        check("x_illegal", 32'(illegal), 32'd1);
        check("x_fire", 32'(issue_fire), 32'd1);
        step();
        set_id(1'b0, X_TYPE, 5'd0, 5'd0, 5'd0);
        check("x_nobusy", busy_mask, 32'h0000_0020);
        set_wb(1'b1, 5'd0);
        step();
        set_wb(1'b0, 5'd0);
        check("wb_x0_silent", 32'(wb_underflow), 32'd0);

        // Flush with no hazard
        flush = 1'b1;
        set_id(1'b1, I_TYPE, 5'd0, 5'd0, 5'd1);
        check("flush_ready", 32'(id_ready), 32'd0);
        check("flush_fire", 32'(issue_fire), 32'd0);
        step();
        flush = 1'b0;
        check("flush_stall", 32'(stall_cnt), 32'd4);
        check("flush_busy", busy_mask, 32'h0000_0020);

        // Hazard while EX not ready is not counted
        ex_ready = 1'b0;
        set_id(1'b1, B_TYPE, 5'd5, 5'd0, 5'd0);
        step();
        check("exnr_stall", 32'(stall_cnt), 32'd4);
        ex_ready = 1'b1;
        set_id(1'b0, B_TYPE, 5'd0, 5'd0, 5'd0);

        // Underflow on rd=12, sticky until reset
        set_wb(1'b1, 5'd12);
        step();
        set_wb(1'b0, 5'd0);
        check("uflow_set", 32'(wb_underflow), 32'd1);
        step(); step();
        check("uflow_sticky", 32'(wb_underflow), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("uflow_clr", 32'(wb_underflow), 32'd0);
        check("rst2_busy", busy_mask, 32'h0);
        check("rst2_stall", 32'(stall_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Register scoreboard between the decode stage and execute. It tracks in-flight destination registers per architectural register and holds a decoded instruction in ID until its sources and destination are free. It also counts hazard-stall cycles for performance monitoring. Inputs are the decoder's `rs1`/`rs2`/`rd`/`OP_type` fields plus writeback retire events; its `id_ready` output gates the ID/EX pipeline register.

## Interface
- `REG_NUM`, 32: number of architectural registers.
- `REG_ADDR_W`, 5: register index width.
- `MAX_INFLIGHT`, 3: maximum outstanding writes per register. Counter width `CNT_W = $clog2(MAX_INFLIGHT+1)`.
- `PERF_W`, 16: stall counter width.

Ports:
- `clk`  in  1  clock. One clock domain; everything updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `id_valid`  in  1  ID stage holds a decoded instruction.
- `id_rs1`, `id_rs2`, `id_rd`  in  REG_ADDR_W each  decoded register fields.
- `id_op_type`  in  7  decoder `OP_type` (`R_type`, `I_type`, `S_type`, `B_type`, `U_type`, `J_type`, `X_type`).
- `ex_ready`  in  1  EX stage can accept this cycle.
- `flush`  in  1  squash the instruction currently in ID.
- `id_ready`  out  1  instruction may leave ID this cycle.
- `issue_fire`  out  1  `id_valid & id_ready`.
- `illegal`  out  1  `id_valid & (id_op_type == X_type)`.
- `wb_valid`  in  1  a write to `wb_rd` retires this cycle.
- `wb_rd`  in  REG_ADDR_W  retiring destination register.
- `busy_mask`  out  REG_NUM  bit i set when cnt[i] != 0. Bit 0 is always 0.
- `stall_cnt`  out  PERF_W  saturating hazard-stall cycle count.
- `wb_underflow`  out  1  sticky error flag.

## Operation
Source and destination usage by op type:
- `R`: uses rs1, rs2 and rd.
- `I`: uses rs1 and rd.
- `S` and `B`: use rs1 and rs2; no rd.
- `U` and `J`: use rd only.
- `X`: uses nothing. It issues as a no-op; trapping is handled elsewhere.
- Register 0 is never a hazard and is never counted.

Hazard and issue:
- `hazard = (uses_rs1 & cnt[rs1]!=0) | (uses_rs2 & cnt[rs2]!=0) | (writes_rd & rd!=0 & cnt[rd]==MAX_INFLIGHT)`.
- `id_ready = ex_ready & ~flush & ~hazard`. This is combinational from the inputs and the registered counts.

Counter update per register i, at each edge:
- `inc = issue_fire & writes_rd & id_rd==i & i!=0`.
- `dec = wb_valid & wb_rd==i & cnt[i]!=0`.
- `cnt[i] <= cnt[i] + inc - dec`. Simultaneous inc and dec on the same register leaves the count unchanged.
- A `wb_valid` with `cnt[wb_rd]==0` and `wb_rd!=0` is ignored and sets `wb_underflow`, which holds until `rst`.
- `wb_rd==0` is always ignored silently.

Stall counter:
- Increments when `id_valid & ex_ready & ~flush & hazard`.
- Saturates at all-ones.
- Cycles stalled only by `~ex_ready` are not counted.

Flush:
- Blocks issue in the same cycle.
- Does not touch counts. In-flight writes still retire through writeback.

## Timing
- Issue decision has zero latency: same-cycle combinational `id_ready`.
- Counts update at the edge after `issue_fire` or `wb_valid`.
- No writeback bypass. A `wb_valid` in cycle N clears the hazard for an ID instruction first in cycle N+1. This conservative choice is fixed.
- Reset: all cnt = 0, `stall_cnt` = 0, `wb_underflow` = 0. Outputs follow: `busy_mask` = 0, and `id_ready` = `ex_ready & ~flush` with no hazards.
- `rst` asserted mid-operation discards all in-flight tracking at that edge. Any writeback arriving afterwards is treated as underflow only if its register count is 0.
- `id_*` inputs must be stable while `id_valid & ~id_ready`. The block keeps no internal copy of the instruction.

## Structure
- `OP_type` and opcode encodings come from the shared `riscv_defs.vh`. Add `SB_MAX_INFLIGHT` there as a default.
- Op-type to uses_rs1/uses_rs2/writes_rd decoding is a combinational `case` local to this block.
- One sub-module, `sb_reg_counter`: a CNT_W up/down counter with inc, dec, a zero flag and a full flag. It is instantiated REG_NUM-1 times in a generate loop (registers 1..31).

## Test plan
- **Reset:** after `rst` = 1 for 2 cycles, `busy_mask` = 0, `stall_cnt` = 0, `wb_underflow` = 0. R-type `rd`=5 with `ex_ready` = 1 → `id_ready` = 1; next cycle `busy_mask[5]` = 1.
- **RAW stall:** issue I-type `rd`=3, then B-type `rs1`=3 → `id_ready` = 0 and `stall_cnt` increments each cycle. `wb_valid`, `wb_rd`=3 in cycle N → `id_ready` = 1 in N+1, not in N.
- **Saturation:** three issues with `rd`=7 and no writeback → a 4th `rd`=7 is held and an S-type `rs1`=7 stalls. One `wb_rd`=7 → the 4th issues; cnt returns to 3.
- **Simultaneous inc/dec:** cnt[9]=1, issue `rd`=9 and `wb_rd`=9 in the same cycle → cnt[9] stays 1 and `busy_mask[9]` = 1.
- **x0 and X-type:** U-type `rd`=0 issues and leaves `busy_mask` = 0. X-type with `id_valid` → `illegal` = 1 and it issues. `wb_rd`=0 → no error.
- **Flush and underflow:** `flush` = 1 with no hazard → `id_ready` = 0 and `stall_cnt` unchanged. `wb_valid`, `wb_rd`=12 with cnt 0 → `wb_underflow` = 1 and stays set until `rst`.
